// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Memory-mapped UART transmitter. The CPU pushes bytes into a small
// circular FIFO; a four-state FSM pops them one at a time and serialises
// each as an 8N1 frame (start bit 0, 8 data bits LSB first, stop bit 1)
// on tx. Each bit lasts CLK_DIV clock cycles.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous reset, active-high
//   wr_en    - write strobe, one byte per cycle
//   wr_data  - byte to enqueue
//   ovf_clr  - synchronous clear of the sticky overflow flag
//   tx       - registered serial output, idles high
//   full     - FIFO holds FIFO_DEPTH entries
//   empty    - FIFO holds no entries
//   busy     - FSM not idle, or bytes still queued
//   overflow - sticky: a write arrived while full and was dropped
//   level    - current FIFO occupancy, 0..FIFO_DEPTH
module uart_tx_fifo #(
  parameter int CLK_DIV    = 87,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  input  logic                        ovf_clr,
  output logic                        tx,
  output logic                        full,
  output logic                        empty,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL    = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nx;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;
  logic             push, pop;
  logic             baud_zero;
  logic             baud_load, shift_en, bit_clr, bit_inc;
  logic             tx_d;

  // Status is decoded from the pre-edge level, so a write while full is
  // dropped even if the FSM pops in the same cycle.
  assign full      = (level == LVL_FULL);
  assign empty     = (level == '0);
  assign busy      = (state != IDLE) || !empty;
  assign push      = wr_en && !full;
  assign baud_zero = (baud_cnt == '0);

  // ---- FIFO storage and pointers ----
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers are PTR_W bits wide and FIFO_DEPTH is a power of two, so
  // the increment wraps modulo FIFO_DEPTH on its own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      // A dropped write takes priority over a clear in the same cycle.
      if (wr_en && full) overflow <= 1'b1;
      else if (ovf_clr)  overflow <= 1'b0;
    end
  end

  // ---- FSM state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // ---- FSM next-state logic ----
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (!empty) state_nx = START;
      START:   if (baud_zero) state_nx = DATA;
      DATA:    if (baud_zero && bit_idx == 3'd7) state_nx = STOP;
      STOP:    if (baud_zero) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---- FSM output logic ----
  // tx_d is the level for the current state; it is registered below, so
  // the line lags the state by one cycle and has no input-to-output path.
  always_comb begin
    tx_d      = 1'b1;
    pop       = 1'b0;
    baud_load = 1'b0;
    shift_en  = 1'b0;
    bit_clr   = 1'b0;
    bit_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          baud_load = 1'b1;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_zero) begin
          baud_load = 1'b1;
          bit_clr   = 1'b1;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_zero) begin
          baud_load = 1'b1;
          shift_en  = 1'b1;
          bit_inc   = (bit_idx != 3'd7);
        end
      end
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // ---- Baud counter, bit index and serial output ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
    end else begin
      if (baud_load)       baud_cnt <= BAUD_RELOAD;
      else if (!baud_zero) baud_cnt <= baud_cnt - CNT_W'(1);
      if (bit_clr)      bit_idx <= '0;
      else if (bit_inc) bit_idx <= bit_idx + 3'd1;
      tx <= tx_d;
    end
  end

  // ---- Shift register ----
  always_ff @(posedge clk) begin
    if (pop)           shift_q <= mem[rd_ptr];
    else if (shift_en) shift_q <= {1'b0, shift_q[7:1]};
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: directed scenarios followed by random
// traffic. A queue-based reference model tracks FIFO contents, the
// overflow flag and when each frame must start; a UART receiver process
// decodes tx and compares every frame against the expected queue.
module tb_uart_tx_fifo;
  localparam int CD    = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          ovf_clr = 1'b0;
  logic          tx, full, empty, busy, overflow;
  logic [LW-1:0] level;

  uart_tx_fifo #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
    .tx(tx), .full(full), .empty(empty), .busy(busy), .overflow(overflow),
    .level(level)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // mq: bytes waiting in the FIFO. fq: frames handed to the transmitter,
  // each with the edge number at which tx must fall.
  typedef struct {
    logic [7:0] b;
    int         start;
  } frame_t;

  logic [7:0] mq[$];
  frame_t     fq[$];
  int         next_free = 0;
  bit         m_ovf     = 1'b0;
  int         m_pre;
  bit         m_fullp;
  frame_t     m_f;

  // A frame occupies 10*CD cycles after its pop plus one IDLE cycle, so the
  // next pop can happen no earlier than 10*CD+1 edges after the previous one.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      mq.delete();
      fq.delete();
      next_free = 0;
      m_ovf     = 1'b0;
    end else begin
      m_pre   = mq.size();
      m_fullp = (m_pre == DEPTH);
      if (m_pre > 0 && cyc >= next_free) begin
        m_f.b     = mq.pop_front();
        m_f.start = cyc + 1;
        fq.push_back(m_f);
        next_free = cyc + 10 * CD + 1;
      end
      if (wr_en && !m_fullp) mq.push_back(wr_data);
      if (wr_en && m_fullp) m_ovf = 1'b1;
      else if (ovf_clr)     m_ovf = 1'b0;
    end
  end

  // ---------------- status checker + UART receiver ----------------
  bit         mon_active = 1'b0;
  int         mon_c      = 0;
  int         mon_err    = 0;
  int         mon_b;
  logic       mon_exp_bit;
  logic [7:0] mon_rx;
  frame_t     mon_f;
  int         n_frames   = 0;
  int         last_start = 0;
  int         prev_start = 0;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_tx", int'(tx), 1);
      check("rst_level", int'(level), 0);
      check("rst_full", int'(full), 0);
      check("rst_empty", int'(empty), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_overflow", int'(overflow), 0);
      mon_active = 1'b0;
    end else begin
      check("level", int'(level), mq.size());
      check("full", int'(full), int'(mq.size() == DEPTH));
      check("empty", int'(empty), int'(mq.size() == 0));
      check("overflow", int'(overflow), int'(m_ovf));
      check("busy", int'(busy), int'((cyc < next_free - 1) || (mq.size() != 0)));

      if (!mon_active && tx == 1'b0) begin
        check("frame_expected", int'(fq.size() != 0), 1);
        if (fq.size() != 0) begin
          mon_f = fq.pop_front();
          check("start_edge", cyc, mon_f.start);
        end else begin
          mon_f.b     = 8'h00;
          mon_f.start = cyc;
        end
        prev_start = last_start;
        last_start = cyc;
        n_frames++;
        mon_active = 1'b1;
        mon_c      = 0;
        mon_err    = 0;
        mon_rx     = 8'h00;
      end
      if (mon_active) begin
        mon_b       = mon_c / CD;
        mon_exp_bit = (mon_b == 0) ? 1'b0 : (mon_b == 9) ? 1'b1 : mon_f.b[mon_b-1];
        if (tx !== mon_exp_bit) mon_err++;
        if (mon_b >= 1 && mon_b <= 8 && (mon_c % CD) == CD / 2) mon_rx[mon_b-1] = tx;
        if (mon_c == 10 * CD - 1) begin
          check("rx_byte", int'(mon_rx), int'(mon_f.b));
          check("frame_shape_errs", mon_err, 0);
          mon_active = 1'b0;
        end
        mon_c++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((mq.size() != 0 || fq.size() != 0 || mon_active || busy) && k < 3000) begin
      tick();
      k++;
    end
    check("drain_in_time", int'(k < 3000), 1);
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  int n_edge, n0, k;

  initial begin
    // Reset held for 3 cycles.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("post_rst_tx", int'(tx), 1);
    check("post_rst_busy", int'(busy), 0);

    // Single byte: tx falls two edges after the write edge.
    wr(8'hA5);
    n_edge = cyc;
    drain();
    check("single_latency", last_start, n_edge + 2);
    check("single_busy_done", int'(busy), 0);

    // Burst of five fills the FIFO without dropping anything.
    for (int i = 1; i <= 5; i++) wr(8'(i));
    check("burst1_no_ovf", int'(overflow), 0);
    repeat (10) tick();
    // Second burst lands while the first frame is in flight: all dropped.
    for (int i = 1; i <= 5; i++) wr(8'(i + 16));
    check("burst2_full", int'(full), 1);
    check("burst2_level", int'(level), DEPTH);
    check("burst2_ovf", int'(overflow), 1);
    // A dropped write beats a clear in the same cycle.
    wr_en = 1'b1; wr_data = 8'hEE; ovf_clr = 1'b1;
    tick();
    wr_en = 1'b0; ovf_clr = 1'b1;
    check("ovf_set_wins", int'(overflow), 1);
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", int'(overflow), 0);
    drain();

    // Back-to-back frames separated by exactly one idle cycle.
    wr(8'h00);
    wr(8'hFF);
    n0 = n_frames;
    drain();
    check("b2b_frames", n_frames - n0, 2);
    check("b2b_period", last_start - prev_start, 10 * CD + 1);

    // Reset during data bit 3 with bytes still queued.
    wr(8'h3C);
    wr(8'h5A);
    wr(8'h96);
    k = 0;
    while (!(mon_active && mon_c == 4 * CD + 2) && k < 500) begin
      tick();
      k++;
    end
    check("reach_bit3", int'(k < 500), 1);
    rst = 1'b1;
    #1;
    check("async_rst_tx", int'(tx), 1);
    check("async_rst_level", int'(level), 0);
    tick();
    tick();
    rst = 1'b0;
    n0 = n_frames;
    repeat (60) tick();
    check("no_frame_after_rst", n_frames - n0, 0);
    check("idle_after_rst", int'(busy), 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      wr_en   = ($urandom_range(0, 9) < 2);
      wr_data = 8'($urandom);
      ovf_clr = ($urandom_range(0, 19) == 0);
      tick();
    end
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    drain();
    check("final_queues_empty", mq.size() + fq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
